// File: rtl/registrador_universal.sv
// ---------------------------------------------------------------------------
// registrador_universal
//
// WIDTH-bit universal register for the ALU datapath. It does single-edge
// LOAD, CLEAR and HOLD operations. It also does multi-bit shifts and rotates
// (SHL, SHR, ROL, ROR, ASR). A shift moves one bit per clock and uses a
// start/busy/done handshake.
//
// Parameters:
//   WIDTH      data word width (>= 2)
//   CNT_W      shift-count width, able to express 0..WIDTH
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      operation request, sampled only while idle
//   mode       000 HOLD, 001 LOAD, 010 SHL, 011 SHR,
//              100 ROL, 101 ROR, 110 ASR, 111 CLEAR
//   d_in       parallel load data
//   amount     shift/rotate count (values above WIDTH clamp to WIDTH)
//   serial_in  fill bit for the vacated position in SHL/SHR
//   q          register contents
//   carry_out  last bit shifted/rotated out
//   busy       shift sequence in progress
//   done       one-cycle completion pulse
//   zero       q == 0, combinational from q
// ---------------------------------------------------------------------------
module registrador_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  // Operation encodings
  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  // Controller states
  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]       state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             carry_reg, carry_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       mode_reg, mode_next;

  // One-step results for every shift flavour, built bit by bit
  logic [WIDTH-1:0] shl_vec;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] rol_vec;
  logic [WIDTH-1:0] ror_vec;
  logic [WIDTH-1:0] asr_vec;

  logic [CNT_W-1:0] amount_eff;
  logic             is_shift_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_carry;

  // -------------------------------------------------------------------------
  // Single-step shift network
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
      // Left-moving operations: bit gi receives bit gi-1, and the LSB
      // receives the fill bit.
      if (gi == 0) begin : g_lsb
        assign shl_vec[gi] = serial_in;
        assign rol_vec[gi] = q_reg[WIDTH-1];
      end else begin : g_lmid
        assign shl_vec[gi] = q_reg[gi-1];
        assign rol_vec[gi] = q_reg[gi-1];
      end

      // Right-moving operations: bit gi receives bit gi+1, and the MSB
      // receives the fill bit.
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_vec[gi] = serial_in;
        assign ror_vec[gi] = q_reg[0];
        assign asr_vec[gi] = q_reg[WIDTH-1];  // sign bit is preserved
      end else begin : g_rmid
        assign shr_vec[gi] = q_reg[gi+1];
        assign ror_vec[gi] = q_reg[gi+1];
        assign asr_vec[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  // Choose the step for the latched mode. Left moves shift out the MSB;
  // right moves shift out the LSB.
  always_comb begin
    step_q     = q_reg;
    step_carry = carry_reg;
    case (mode_reg)
      MODE_SHL: begin step_q = shl_vec; step_carry = q_reg[WIDTH-1]; end
      MODE_SHR: begin step_q = shr_vec; step_carry = q_reg[0];       end
      MODE_ROL: begin step_q = rol_vec; step_carry = q_reg[WIDTH-1]; end
      MODE_ROR: begin step_q = ror_vec; step_carry = q_reg[0];       end
      MODE_ASR: begin step_q = asr_vec; step_carry = q_reg[0];       end
      default:  begin step_q = q_reg;   step_carry = carry_reg;      end
    endcase
  end

  // Counts above WIDTH are clamped. A full-width rotate therefore returns
  // the original word, and a full-width shift flushes every bit.
  assign amount_eff = (amount > CNT_MAX) ? CNT_MAX : amount;

  assign is_shift_mode = (mode == MODE_SHL) || (mode == MODE_SHR) ||
                         (mode == MODE_ROL) || (mode == MODE_ROR) ||
                         (mode == MODE_ASR);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    carry_next = carry_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;  // done is a pulse and drops unless re-raised below
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;

    case (state_reg)
      STATE_IDLE: begin
        if (start) begin
          case (mode)
            MODE_HOLD: begin
              done_next = 1'b1;
            end
            MODE_LOAD: begin
              q_next     = d_in;
              carry_next = 1'b0;
              done_next  = 1'b1;
            end
            MODE_CLEAR: begin
              q_next     = '0;
              carry_next = 1'b0;
              done_next  = 1'b1;
            end
            default: begin
              if (is_shift_mode) begin
                if (amount_eff == '0) begin
                  // A zero-length shift completes immediately and leaves
                  // q and carry_out untouched.
                  done_next = 1'b1;
                end else begin
                  // q is not modified on the accepting edge. The first step
                  // lands on the following edge.
                  mode_next  = mode;
                  cnt_next   = amount_eff;
                  busy_next  = 1'b1;
                  state_next = STATE_SHIFT;
                end
              end
            end
          endcase
        end
      end

      STATE_SHIFT: begin
        q_next     = step_q;
        carry_next = step_carry;
        cnt_next   = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          // Last step: done and busy=0 appear together in the next cycle.
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = STATE_IDLE;
        end
      end

      default: begin
        state_next = STATE_IDLE;
        busy_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= STATE_IDLE;
      q_reg     <= '0;
      carry_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
      mode_reg  <= MODE_HOLD;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      carry_reg <= carry_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
    end
  end

  assign q         = q_reg;
  assign carry_out = carry_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign zero      = (q_reg == '0);

endmodule

// File: tb/tb_registrador_universal.sv
// ---------------------------------------------------------------------------
// tb_registrador_universal
//
// Directed self-checking bench for registrador_universal with WIDTH=8.
// Inputs change on the falling edge. Outputs are sampled 1ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_registrador_universal;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  logic             clk;
  logic             reset;
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d_in;
  logic [CNT_W-1:0] amount;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             carry_out;
  logic             busy;
  logic             done;
  logic             zero;

  int n_checks;
  int n_fail;

  registrador_universal #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .d_in      (d_in),
    .amount    (amount),
    .serial_in (serial_in),
    .q         (q),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus helper: present one request for exactly one rising edge.
  // It returns 1ns after that edge, which is the accepting edge k.
  task automatic issue(input logic [2:0] m, input logic [7:0] d,
                       input logic [3:0] amt, input logic sin);
    @(negedge clk);
    start     = 1'b1;
    mode      = m;
    d_in      = d;
    amount    = amt;
    serial_in = sin;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    issue(M_LOAD, 8'h5A, 4'd0, 1'b0);
    // Assert reset mid-cycle. The outputs must clear with no clock edge.
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (q !== 8'h00 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || carry_out !== 1'b0) begin
      $display("FAIL reset_async q=%h zero=%b busy=%b done=%b carry=%b exp q=00 zero=1 busy=0 done=0 carry=0",
               q, zero, busy, done, carry_out);
      n_fail++;
    end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset: q=%h zero=%b", q, zero);
  endtask

  task automatic test_load_clear;
    issue(M_LOAD, 8'hA5, 4'd0, 1'b0);
    n_checks++;
    if (q !== 8'hA5 || done !== 1'b1 || busy !== 1'b0 || zero !== 1'b0) begin
      $display("FAIL load q=%h done=%b busy=%b zero=%b exp q=a5 done=1 busy=0 zero=0", q, done, busy, zero);
      n_fail++;
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 8'hA5) begin
      $display("FAIL load_done_pulse done=%b busy=%b q=%h exp done=0 busy=0 q=a5", done, busy, q);
      n_fail++;
    end
    issue(M_CLEAR, 8'hFF, 4'd0, 1'b0);
    n_checks++;
    if (q !== 8'h00 || zero !== 1'b1 || done !== 1'b1 || carry_out !== 1'b0) begin
      $display("FAIL clear q=%h zero=%b done=%b carry=%b exp q=00 zero=1 done=1 carry=0", q, zero, done, carry_out);
      n_fail++;
    end
    $display("test_load_clear: q=%h", q);
  endtask

  task automatic test_shl;
    logic [7:0] exp_q [3];
    logic       exp_c [3];
    exp_q[0] = 8'h4B; exp_c[0] = 1'b1;
    exp_q[1] = 8'h97; exp_c[1] = 1'b0;
    exp_q[2] = 8'h2F; exp_c[2] = 1'b1;
    issue(M_LOAD, 8'hA5, 4'd0, 1'b0);
    issue(M_SHL, 8'h00, 4'd3, 1'b1);
    n_checks++;
    if (busy !== 1'b1 || q !== 8'hA5 || done !== 1'b0) begin
      $display("FAIL shl_accept busy=%b q=%h done=%b exp busy=1 q=a5 done=0", busy, q, done);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (q !== exp_q[i] || carry_out !== exp_c[i] || busy !== (i < 2) || done !== (i == 2)) begin
        $display("FAIL shl_step%0d q=%h carry=%b busy=%b done=%b exp q=%h carry=%b busy=%b done=%b",
                 i + 1, q, carry_out, busy, done, exp_q[i], exp_c[i], (i < 2), (i == 2));
        n_fail++;
      end
    end
    $display("test_shl: q=%h carry=%b", q, carry_out);
  endtask

  task automatic test_zero_amount;
    // This starts from SHL's final state: q=2f and carry=1.
    issue(M_SHR, 8'h00, 4'd0, 1'b0);
    n_checks++;
    if (q !== 8'h2F || carry_out !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL shr_zero q=%h carry=%b done=%b busy=%b exp q=2f carry=1 done=1 busy=0",
               q, carry_out, done, busy);
      n_fail++;
    end
    issue(M_HOLD, 8'hFF, 4'd0, 1'b0);
    n_checks++;
    if (q !== 8'h2F || carry_out !== 1'b1 || done !== 1'b1) begin
      $display("FAIL hold q=%h carry=%b done=%b exp q=2f carry=1 done=1", q, carry_out, done);
      n_fail++;
    end
    $display("test_zero_amount: q=%h", q);
  endtask

  task automatic test_rotates;
    issue(M_LOAD, 8'h81, 4'd0, 1'b0);
    issue(M_ROR, 8'h00, 4'd1, 1'b0);
    step();
    n_checks++;
    if (q !== 8'hC0 || carry_out !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL ror1 q=%h carry=%b done=%b busy=%b exp q=c0 carry=1 done=1 busy=0", q, carry_out, done, busy);
      n_fail++;
    end

    issue(M_LOAD, 8'h80, 4'd0, 1'b0);
    issue(M_ASR, 8'h00, 4'd7, 1'b0);
    for (int i = 0; i < 7; i++) step();
    n_checks++;
    if (q !== 8'hFF || carry_out !== 1'b0 || done !== 1'b1) begin
      $display("FAIL asr7 q=%h carry=%b done=%b exp q=ff carry=0 done=1", q, carry_out, done);
      n_fail++;
    end

    // A count of 12 clamps to 8, so this is a full rotate.
    issue(M_LOAD, 8'h3C, 4'd0, 1'b0);
    issue(M_ROL, 8'h00, 4'd12, 1'b0);
    for (int i = 0; i < 7; i++) step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || q !== 8'h1E) begin
      $display("FAIL rol12_step7 q=%h done=%b busy=%b exp q=1e done=0 busy=1", q, done, busy);
      n_fail++;
    end
    step();
    n_checks++;
    if (q !== 8'h3C || done !== 1'b1 || busy !== 1'b0 || carry_out !== 1'b0) begin
      $display("FAIL rol12_final q=%h done=%b busy=%b carry=%b exp q=3c done=1 busy=0 carry=0",
               q, done, busy, carry_out);
      n_fail++;
    end
    $display("test_rotates: q=%h", q);
  endtask

  task automatic test_ignore_busy;
    issue(M_LOAD, 8'h0F, 4'd0, 1'b0);
    issue(M_SHR, 8'h00, 4'd4, 1'b0);
    // Present a LOAD request while busy. It must have no effect.
    @(negedge clk);
    start = 1'b1; mode = M_LOAD; d_in = 8'h55; amount = 4'd2;
    step();
    @(negedge clk);
    step();
    start = 1'b0;
    n_checks++;
    if (q !== 8'h03 || busy !== 1'b1) begin
      $display("FAIL shr_busy_ignore q=%h busy=%b exp q=03 busy=1", q, busy);
      n_fail++;
    end
    step(); step();
    n_checks++;
    if (q !== 8'h00 || carry_out !== 1'b1 || zero !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL shr4 q=%h carry=%b zero=%b done=%b busy=%b exp q=00 carry=1 zero=1 done=1 busy=0",
               q, carry_out, zero, done, busy);
      n_fail++;
    end
    step();
    n_checks++;
    if (done !== 1'b0 || q !== 8'h00) begin
      $display("FAIL shr4_single_done done=%b q=%h exp done=0 q=00", done, q);
      n_fail++;
    end
    $display("test_ignore_busy: q=%h", q);
  endtask

  task automatic test_back_to_back;
    issue(M_LOAD, 8'h01, 4'd0, 1'b0);
    issue(M_ROL, 8'h00, 4'd1, 1'b0);
    step();
    n_checks++;
    if (q !== 8'h02 || done !== 1'b1) begin
      $display("FAIL b2b_rol q=%h done=%b exp q=02 done=1", q, done);
      n_fail++;
    end
    // Start the next request while done is still high.
    issue(M_LOAD, 8'hAA, 4'd0, 1'b0);
    n_checks++;
    if (q !== 8'hAA || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL b2b_load q=%h done=%b busy=%b exp q=aa done=1 busy=0", q, done, busy);
      n_fail++;
    end
    $display("test_back_to_back: q=%h", q);
  endtask

  task automatic test_reset_mid_shift;
    int seen_done;
    issue(M_LOAD, 8'hFF, 4'd0, 1'b0);
    issue(M_SHL, 8'h00, 4'd5, 1'b0);
    step(); step();
    n_checks++;
    if (q !== 8'hFC || busy !== 1'b1) begin
      $display("FAIL shl5_mid q=%h busy=%b exp q=fc busy=1", q, busy);
      n_fail++;
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1 || carry_out !== 1'b0) begin
      $display("FAIL reset_mid_shift q=%h busy=%b done=%b zero=%b carry=%b exp q=00 busy=0 done=0 zero=1 carry=0",
               q, busy, done, zero, carry_out);
      n_fail++;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      $display("FAIL reset_abort_quiet cycles_with_done_or_busy=%0d exp 0", seen_done);
      n_fail++;
    end
    issue(M_LOAD, 8'h01, 4'd0, 1'b0);
    n_checks++;
    if (q !== 8'h01 || done !== 1'b1 || zero !== 1'b0) begin
      $display("FAIL load_after_reset q=%h done=%b zero=%b exp q=01 done=1 zero=0", q, done, zero);
      n_fail++;
    end
    $display("test_reset_mid_shift: q=%h", q);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    mode      = M_HOLD;
    d_in      = '0;
    amount    = '0;
    serial_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_load_clear();
    test_shl();
    test_zero_amount();
    test_rotates();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_shift();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guards against a hung simulation.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
